// File: rtl/request_unit.sv
// Request sequencer between memory and control unit: fetch/exec/dmem/halt phases,
// instruction latch, memory request strobes and the single-cycle PC advance pulse.
module request_unit #(
    parameter logic [31:0] RESET_INS = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] iload,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        haltReq,
    output logic [31:0] ins,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        pcEn,
    output logic        halted
);

    localparam logic [1:0] IFETCH = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] DMEM   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] ins_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IFETCH;
            ins_q   <= RESET_INS;
        end else begin
            state_q <= state_d;
            if (state_q == IFETCH && ihit) begin
                ins_q <= iload;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        pcEn    = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            IFETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Halt outranks any memory op decoded alongside it.
                if (haltReq) begin
                    state_d = HALTED;
                end else if (memRead || memWrite) begin
                    state_d = DMEM;
                end else begin
                    pcEn    = 1'b1;
                    state_d = IFETCH;
                end
            end
            DMEM: begin
                // Write wins when both are decoded so the two strobes stay exclusive.
                dmemWEN = memWrite;
                dmemREN = memRead & ~memWrite;
                if (dhit) begin
                    pcEn    = 1'b1;
                    state_d = IFETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IFETCH;
            end
        endcase
    end

    assign ins = ins_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed self-checking bench for request_unit; outputs are checked as the packed
// vector {imemREN, dmemREN, dmemWEN, pcEn, halted} plus the latched ins.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic        memRead;
    logic        memWrite;
    logic        haltReq;
    logic [31:0] ins;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        pcEn;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [4:0] outs;
    assign outs = {imemREN, dmemREN, dmemWEN, pcEn, halted};

    request_unit #(.RESET_INS(32'h00000000)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .memRead  (memRead),
        .memWrite (memWrite),
        .haltReq  (haltReq),
        .ins      (ins),
        .imemREN  (imemREN),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .pcEn     (pcEn),
        .halted   (halted)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled around the falling edge.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 0; dhit = 0; iload = 32'h0; memRead = 0; memWrite = 0; haltReq = 0;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        ihit  = 1'b1;
        iload = word;
        tick();
        ihit  = 1'b0;
        iload = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST   = 1'b1;
        ihit  = 1'b1;
        iload = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ins !== 32'h0) begin
                failures++;
                $display("FAIL reset_ins cyc%0d got %h want %h", i, ins, 32'h0);
            end
            checks++;
            if (outs !== 5'b10000) begin
                failures++;
                $display("FAIL reset_outs cyc%0d got %b want %b", i, outs, 5'b10000);
            end
        end
        RST  = 1'b0;
        ihit = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b10000 || ins !== 32'h0) begin
            failures++;
            $display("FAIL reset_release got outs=%b ins=%h want outs=10000 ins=0", outs, ins);
        end
    endtask

    task automatic test_alu();
        ihit  = 1'b1;
        iload = 32'h012A4020;
        #1;
        checks++;
        if (outs !== 5'b10000) begin
            failures++;
            $display("FAIL alu_fetch got %b want %b", outs, 5'b10000);
        end
        tick();
        ihit  = 1'b0;
        iload = 32'h0;
        #1;
        checks++;
        if (ins !== 32'h012A4020) begin
            failures++;
            $display("FAIL alu_ins got %h want %h", ins, 32'h012A4020);
        end
        checks++;
        if (outs !== 5'b00010) begin
            failures++;
            $display("FAIL alu_exec got %b want %b", outs, 5'b00010);
        end
        tick();
        checks++;
        if (outs !== 5'b10000 || ins !== 32'h012A4020) begin
            failures++;
            $display("FAIL alu_refetch got outs=%b ins=%h want outs=10000 ins=012a4020",
                     outs, ins);
        end
    endtask

    task automatic test_load_wait();
        do_fetch(32'h8D090004);
        memRead = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000 || ins !== 32'h8D090004) begin
            failures++;
            $display("FAIL load_exec got outs=%b ins=%h want outs=00000 ins=8d090004", outs, ins);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            dhit = (i == 2);
            #1;
            checks++;
            if (outs !== ((i == 2) ? 5'b01010 : 5'b01000)) begin
                failures++;
                $display("FAIL load_dmem cyc%0d got %b want %b", i, outs,
                         (i == 2) ? 5'b01010 : 5'b01000);
            end
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b10000) begin
            failures++;
            $display("FAIL load_return got %b want %b", outs, 5'b10000);
        end
    endtask

    task automatic test_rw_conflict();
        do_fetch(32'hAC0A0008);
        memRead  = 1'b1;
        memWrite = 1'b1;
        tick();
        ihit  = 1'b1;
        iload = 32'hFFFFFFFF;
        #1;
        checks++;
        if (outs !== 5'b00100) begin
            failures++;
            $display("FAIL rw_dmem got %b want %b", outs, 5'b00100);
        end
        tick();
        checks++;
        if (outs !== 5'b00100 || ins !== 32'hAC0A0008) begin
            failures++;
            $display("FAIL rw_ihit_ignored got outs=%b ins=%h want outs=00100 ins=ac0a0008",
                     outs, ins);
        end
        ihit = 1'b0;
        dhit = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00110) begin
            failures++;
            $display("FAIL rw_dhit got %b want %b", outs, 5'b00110);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b10000 || ins !== 32'hAC0A0008) begin
            failures++;
            $display("FAIL rw_return got outs=%b ins=%h want outs=10000 ins=ac0a0008", outs, ins);
        end
    endtask

    task automatic test_halt();
        do_fetch(32'hFC000000);
        haltReq  = 1'b1;
        memWrite = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            failures++;
            $display("FAIL halt_exec got %b want %b", outs, 5'b00000);
        end
        tick();
        checks++;
        if (outs !== 5'b00001) begin
            failures++;
            $display("FAIL halt_enter got %b want %b", outs, 5'b00001);
        end
        for (int i = 0; i < 10; i++) begin
            ihit  = i[0];
            dhit  = ~i[0];
            iload = 32'h1000_0000 + i;
            tick();
            checks++;
            if (outs !== 5'b00001 || ins !== 32'hFC000000) begin
                failures++;
                $display("FAIL halt_hold cyc%0d got outs=%b ins=%h want outs=00001 ins=fc000000",
                         i, outs, ins);
            end
        end
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b10000 || ins !== 32'h0) begin
            failures++;
            $display("FAIL halt_reset got outs=%b ins=%h want outs=10000 ins=0", outs, ins);
        end
    endtask

    task automatic test_reset_mid_access();
        do_fetch(32'h8D090004);
        memRead = 1'b1;
        tick();
        checks++;
        if (outs !== 5'b01000) begin
            failures++;
            $display("FAIL mid_dmem1 got %b want %b", outs, 5'b01000);
        end
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01000) begin
            failures++;
            $display("FAIL mid_dmem2 got %b want %b", outs, 5'b01000);
        end
        tick();
        checks++;
        if (outs !== 5'b10000 || ins !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got outs=%b ins=%h want outs=10000 ins=0", outs, ins);
        end
        RST = 1'b0;
        clear_inputs();
        tick();
        checks++;
        if (outs !== 5'b10000) begin
            failures++;
            $display("FAIL mid_after got %b want %b", outs, 5'b10000);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_rw_conflict();
        test_halt();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
